serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 157 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: drives one shared 1-bit full adder over WIDTH cycles, LSB first.
// Optional SERIAL_SUB_EN adds a 'sub' input that turns the operation into a - b.

module full_adder_1b (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_c,
    output logic co_c
);
    assign s_c  = a_i ^ b_i ^ c_i;
    assign co_c = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               fa_s, fa_co;
    logic [WIDTH-1:0]   op_b;
    logic               op_c;
    logic [WIDTH:0]     res_cat;
    logic               unused_res_lsb;

    full_adder_1b u_fa (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .c_i  (carry_q),
        .s_c  (fa_s),
        .co_c (fa_co)
    );

    // The LSB of the result shifter always falls off the end; it is never a result bit.
    assign res_cat        = {fa_s, res_sh_q};
    assign unused_res_lsb = res_cat[0];

    // Operand B / carry-in as loaded on accept (inverted B plus one for subtraction).
    always_comb begin
        op_b = b;
        op_c = cin;
`ifdef SERIAL_SUB_EN
        if (sub) begin
            op_b = ~b;
            op_c = 1'b1;
        end
`endif
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
        busy_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = op_b;
                    carry_d = op_c;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_co;
                res_sh_d = res_cat[WIDTH:1];
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = res_cat[WIDTH:1];
                    cout_d  = fa_co;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: directed cases plus random start/operand traffic.

module tb_serial_adder_ctrl;
    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           dc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub_r = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int           cyc = 0;
    int           free_at = 0;
    int           total = 0;
    int           bad = 0;
    exp_t         sb[$];
    logic [W-1:0] last_s = '0;
    logic         last_c = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_SUB_EN
        .sub   (sub_r),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
        end
    endfunction

    // Monitor: every cycle check busy, done and the held/updated result against the model.
    always @(negedge clk) begin
        logic exp_busy, exp_done;
        exp_t e;
        exp_busy = (cyc < free_at) && (cyc >= free_at - int'(W));
        exp_done = (sb.size() > 0) && (sb[0].dc == cyc);
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("done", 64'(done), 64'(exp_done));
        if (exp_done) begin
            e = sb.pop_front();
            last_s = e.s;
            last_c = e.c;
        end
        chk("sum", 64'(sum), 64'(last_s));
        chk("cout", 64'(cout), 64'(last_c));
    end

    // One driver cycle; the model decides acceptance from its own idea of when the unit is free.
    task automatic step(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb_i);
        int unsigned  tot;
        logic [W-1:0] bb;
        logic         cc;
        exp_t         e;
        @(posedge clk);
        #2;
        start = st;
        a     = av;
        b     = bv;
        cin   = ci;
        sub_r = sb_i;
        if (st && cyc >= free_at) begin
            bb = bv;
            cc = ci;
`ifdef SERIAL_SUB_EN
            if (sb_i) begin
                bb = ~bv;
                cc = 1'b1;
            end
`endif
            tot  = int'(av) + int'(bb) + int'(cc);
            e.s  = W'(tot);
            e.c  = tot[W];
            e.dc = cyc + 1 + int'(W);
            sb.push_back(e);
            free_at = e.dc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        sb.delete();
        free_at = 0;
        last_s = '0;
        last_c = 1'b0;
        repeat (n) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset(2);
        idle(2);

        step(1'b1, 8'h3C, 8'h5A, 1'b0, 1'b0);
        idle(W + 2);

        step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        idle(W + 1);
        step(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(W + 2);

        // Start while busy must be ignored.
        step(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        idle(W + 2);

        // Start held high: back-to-back accepts from the DONE cycle.
        for (int i = 0; i < 3 * (int'(W) + 1); i++) step(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
        idle(W + 2);

        // Reset in the 4th RUN cycle discards the operation.
        step(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0);
        idle(3);
        do_reset(2);
        idle(2);
        step(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0);
        idle(W + 2);

`ifdef SERIAL_SUB_EN
        step(1'b1, 8'h10, 8'h01, 1'b1, 1'b1);
        idle(W + 1);
        step(1'b1, 8'h00, 8'h01, 1'b0, 1'b1);
        idle(W + 2);
`endif

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) == 0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        idle(W + 3);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
